fetch_stage: RTL

- Instruction-fetch stage of the pipelined RV32I core; sits directly upstream of the instruction memory.
- Holds the program counter and drives the fetch address to the memory.
- Computes the sequential next PC and selects a branch/jump redirect.
- Registers the returned instruction, its PC and PC+4 into the IF/ID pipeline register.
- Handles stall, flush and bubble tracking for the decode stage.

---
 rtl/fetch_stage_if.sv | 64 ++++++
 rtl/fetch_stage.sv | 105 ++++++++++
 2 files changed

// File: rtl/fetch_stage_if.sv
// -----------------------------------------------------------------------------
// fetch_stage_if
//   Bundles every non-clock/reset signal of the instruction-fetch stage:
//   the hazard-unit controls, the execute-stage redirect, the instruction
//   memory bus and the IF/ID pipeline register outputs.
//
//   Signals
//     StallF     hazard unit -> fetch   hold PC register
//     StallD     hazard unit -> fetch   hold IF/ID register
//     FlushD     hazard unit -> fetch   turn IF/ID into a bubble
//     PCSrcE     execute     -> fetch   taken branch / jump redirect request
//     PCTargetE  execute     -> fetch   redirect target (bits [1:0] ignored)
//     InstrF     imem        -> fetch   instruction word for PCF (combinational)
//     PCF        fetch       -> imem    current fetch address (registered)
//     InstrD     fetch       -> decode  registered instruction
//     PCD        fetch       -> decode  PC of InstrD
//     PCPlus4D   fetch       -> decode  PCD + 4
//     ValidD     fetch       -> decode  1 = real instruction, 0 = bubble
//
//   Modports
//     master : the fetch stage itself
//     slave  : the surrounding core / memory / test environment
// -----------------------------------------------------------------------------
interface fetch_stage_if;
   logic        StallF;
   logic        StallD;
   logic        FlushD;
   logic        PCSrcE;
   logic [31:0] PCTargetE;
   logic [31:0] InstrF;
   logic [31:0] PCF;
   logic [31:0] InstrD;
   logic [31:0] PCD;
   logic [31:0] PCPlus4D;
   logic        ValidD;

   modport master (
      input  StallF,
      input  StallD,
      input  FlushD,
      input  PCSrcE,
      input  PCTargetE,
      input  InstrF,
      output PCF,
      output InstrD,
      output PCD,
      output PCPlus4D,
      output ValidD
   );

   modport slave (
      output StallF,
      output StallD,
      output FlushD,
      output PCSrcE,
      output PCTargetE,
      output InstrF,
      input  PCF,
      input  InstrD,
      input  PCD,
      input  PCPlus4D,
      input  ValidD
   );
endinterface

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//   Instruction-fetch stage of the pipelined RV32I core. Owns the program
//   counter, drives the fetch address to instruction memory, selects between
//   the sequential PC+4 and an execute-stage redirect, and captures the
//   returned instruction with its PC and PC+4 into the IF/ID register.
//
//   Ports
//     clk  : system clock, all state updates on the rising edge
//     rst  : synchronous active-low reset (0 = reset)
//     fif  : fetch_stage_if.master (controls, imem bus, IF/ID outputs)
//
//   Parameters
//     RESET_PC : PC loaded on reset, must be word aligned
//     XLEN     : datapath width, only 32 is supported
// -----------------------------------------------------------------------------
module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned XLEN     = 32
) (
   input  logic                clk,
   input  logic                rst,
   fetch_stage_if.master       fif
);

   localparam logic [XLEN-1:0] NOP_INSTR  = 32'h0000_0013;   // addi x0,x0,0
   localparam logic [XLEN-1:0] ALIGN_MASK = 32'hFFFF_FFFC;

   logic [XLEN-1:0] pc_q,       pc_d;
   logic [XLEN-1:0] instr_q,    instr_d;
   logic [XLEN-1:0] pcd_q,      pcd_d;
   logic [XLEN-1:0] pcplus4_q,  pcplus4_d;
   logic            valid_q,    valid_d;
   logic [XLEN-1:0] pc_plus4_s;
   logic [XLEN-1:0] target_s;

   // Sequential next PC (wraps modulo 2^32) and the word-aligned redirect target.
   always_comb begin
      pc_plus4_s = pc_q + 32'd4;
      target_s   = fif.PCTargetE & ALIGN_MASK;
   end

   // PC next-state: a redirect beats a stall so a taken branch is never dropped.
   always_comb begin
      pc_d = pc_q;
      if (fif.PCSrcE) begin
         pc_d = target_s;
      end else if (fif.StallF) begin
         pc_d = pc_q;
      end else begin
         pc_d = pc_plus4_s;
      end
   end

   // IF/ID next-state: a flush beats a stall so the wrong-path instruction is squashed.
   always_comb begin
      instr_d   = instr_q;
      pcd_d     = pcd_q;
      pcplus4_d = pcplus4_q;
      valid_d   = valid_q;
      if (fif.FlushD) begin
         instr_d   = NOP_INSTR;
         pcd_d     = 32'h0000_0000;
         pcplus4_d = 32'h0000_0000;
         valid_d   = 1'b0;
      end else if (fif.StallD) begin
         instr_d   = instr_q;
         pcd_d     = pcd_q;
         pcplus4_d = pcplus4_q;
         valid_d   = valid_q;
      end else begin
         instr_d   = fif.InstrF;
         pcd_d     = pc_q;
         pcplus4_d = pc_plus4_s;
         valid_d   = 1'b1;
      end
   end

   // State registers with synchronous active-low reset overriding every control.
   always_ff @(posedge clk) begin
      if (!rst) begin
         pc_q      <= RESET_PC;
         instr_q   <= 32'h0000_0000;
         pcd_q     <= 32'h0000_0000;
         pcplus4_q <= 32'h0000_0000;
         valid_q   <= 1'b0;
      end else begin
         pc_q      <= pc_d;
         instr_q   <= instr_d;
         pcd_q     <= pcd_d;
         pcplus4_q <= pcplus4_d;
         valid_q   <= valid_d;
      end
   end

   // All outputs come straight from flops; no input reaches PCF combinationally.
   always_comb begin
      fif.PCF      = pc_q;
      fif.InstrD   = instr_q;
      fif.PCD      = pcd_q;
      fif.PCPlus4D = pcplus4_q;
      fif.ValidD   = valid_q;
   end

endmodule
